sdr_port_arbiter: RTL and testbench

- Shares one toggle-handshake SDRAM channel between two requesters: port 0 is the main V30 CPU ROM/RAM path, port 1 is the sound CPU ROM/RAM path.
- Sits between the requesters and the SDRAM controller channel (sdr_*1).
- Latches the granted request, forwards it downstream, and returns read data plus an ack toggle to the owner.
- Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/sdr_port_arbiter.sv | 137 +++++++++++++
 tb/tb_sdr_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdr_port_arbiter.sv
// sdr_port_arbiter
//   Shares one toggle-handshake SDRAM channel between two requesters:
//   port 0 (main V30 CPU ROM/RAM) and port 1 (sound CPU ROM/RAM).
//   The granted request is latched and forwarded downstream. Read data and
//   an ack toggle are returned to the owning port only.
//
// Parameters
//   FAIR        1 = round-robin on ties, 0 = port 0 always wins ties
//
// Ports
//   CLK_32M     system clock, rising edge
//   reset_n     asynchronous active-low reset
//   mN_addr     port N word address [24:1]
//   mN_din      port N write data
//   mN_wr_sel   port N byte write enables (00 = read)
//   mN_req      port N request toggle
//   mN_ack      port N completion toggle
//   mN_dout     port N read data
//   sdr_addr    downstream word address
//   sdr_din     downstream write data
//   sdr_wr_sel  downstream byte write enables
//   sdr_req     downstream request toggle
//   sdr_ack     downstream completion toggle
//   sdr_dout    downstream read data, valid when sdr_ack == sdr_req
//   busy        downstream transaction outstanding
//   grant       owner of the current or last transaction
module sdr_port_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        CLK_32M,
  input  logic        reset_n,

  input  logic [23:0] m0_addr,
  input  logic [15:0] m0_din,
  input  logic [1:0]  m0_wr_sel,
  input  logic        m0_req,
  output logic        m0_ack,
  output logic [15:0] m0_dout,

  input  logic [23:0] m1_addr,
  input  logic [15:0] m1_din,
  input  logic [1:0]  m1_wr_sel,
  input  logic        m1_req,
  output logic        m1_ack,
  output logic [15:0] m1_dout,

  output logic [23:0] sdr_addr,
  output logic [15:0] sdr_din,
  output logic [1:0]  sdr_wr_sel,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_dout,

  output logic        busy,
  output logic        grant
);

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t state, state_nx;

  logic last_grant;
  logic pend0, pend1;
  logic sel;
  logic do_grant;
  logic do_done;

  assign pend0 = m0_req ^ m0_ack;
  assign pend1 = m1_req ^ m1_ack;

  // State register
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (pend0 || pend1)     state_nx = WAIT;
      WAIT: if (sdr_ack == sdr_req) state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

  // Decode: which port wins, and the grant/completion strobes
  always_comb begin
    if (pend0 && pend1) sel = FAIR ? ~last_grant : 1'b0;
    else                sel = pend1;
    do_grant = (state == IDLE) && (pend0 || pend1);
    do_done  = (state == WAIT) && (sdr_ack == sdr_req);
  end

  // Registered datapath. Completion clears busy and returns to IDLE on the
  // same edge, so the earliest next grant is one edge later; that gap lets
  // the downstream controller observe req == ack between transactions.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_dout    <= '0;
      m1_dout    <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      sdr_wr_sel <= '0;
      sdr_req    <= 1'b0;
      busy       <= 1'b0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (do_grant) begin
        sdr_addr   <= sel ? m1_addr   : m0_addr;
        sdr_din    <= sel ? m1_din    : m0_din;
        sdr_wr_sel <= sel ? m1_wr_sel : m0_wr_sel;
        sdr_req    <= ~sdr_req;
        grant      <= sel;
        last_grant <= sel;
        busy       <= 1'b1;
      end
      if (do_done) begin
        busy <= 1'b0;
        if (grant) begin
          m1_ack <= m1_req;
          if (sdr_wr_sel == 2'b00) m1_dout <= sdr_dout;
        end else begin
          m0_ack <= m0_req;
          if (sdr_wr_sel == 2'b00) m0_dout <= sdr_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdr_port_arbiter.sv
module tb_sdr_port_arbiter;

  logic CLK_32M;
  logic reset_n;

  int tests;
  int failed;

  // Instance a: FAIR=1
  logic [23:0] a_m0_addr, a_m1_addr, a_sdr_addr;
  logic [15:0] a_m0_din, a_m1_din, a_m0_dout, a_m1_dout, a_sdr_din, a_sdr_dout;
  logic [1:0]  a_m0_wr_sel, a_m1_wr_sel, a_sdr_wr_sel;
  logic        a_m0_req, a_m1_req, a_m0_ack, a_m1_ack;
  logic        a_sdr_req, a_sdr_ack, a_busy, a_grant;

  // Instance b: FAIR=0
  logic [23:0] b_m0_addr, b_m1_addr, b_sdr_addr;
  logic [15:0] b_m0_din, b_m1_din, b_m0_dout, b_m1_dout, b_sdr_din, b_sdr_dout;
  logic [1:0]  b_m0_wr_sel, b_m1_wr_sel, b_sdr_wr_sel;
  logic        b_m0_req, b_m1_req, b_m0_ack, b_m1_ack;
  logic        b_sdr_req, b_sdr_ack, b_busy, b_grant;

  // Downstream model controls
  int          a_lat, b_lat, a_cnt, b_cnt;
  logic        a_mode;          // 1: read data = ~addr[15:0], 0: a_rdata
  logic [15:0] a_rdata;

  sdr_port_arbiter #(.FAIR(1'b1)) u_fair (
    .CLK_32M(CLK_32M), .reset_n(reset_n),
    .m0_addr(a_m0_addr), .m0_din(a_m0_din), .m0_wr_sel(a_m0_wr_sel),
    .m0_req(a_m0_req), .m0_ack(a_m0_ack), .m0_dout(a_m0_dout),
    .m1_addr(a_m1_addr), .m1_din(a_m1_din), .m1_wr_sel(a_m1_wr_sel),
    .m1_req(a_m1_req), .m1_ack(a_m1_ack), .m1_dout(a_m1_dout),
    .sdr_addr(a_sdr_addr), .sdr_din(a_sdr_din), .sdr_wr_sel(a_sdr_wr_sel),
    .sdr_req(a_sdr_req), .sdr_ack(a_sdr_ack), .sdr_dout(a_sdr_dout),
    .busy(a_busy), .grant(a_grant)
  );

  sdr_port_arbiter #(.FAIR(1'b0)) u_prio (
    .CLK_32M(CLK_32M), .reset_n(reset_n),
    .m0_addr(b_m0_addr), .m0_din(b_m0_din), .m0_wr_sel(b_m0_wr_sel),
    .m0_req(b_m0_req), .m0_ack(b_m0_ack), .m0_dout(b_m0_dout),
    .m1_addr(b_m1_addr), .m1_din(b_m1_din), .m1_wr_sel(b_m1_wr_sel),
    .m1_req(b_m1_req), .m1_ack(b_m1_ack), .m1_dout(b_m1_dout),
    .sdr_addr(b_sdr_addr), .sdr_din(b_sdr_din), .sdr_wr_sel(b_sdr_wr_sel),
    .sdr_req(b_sdr_req), .sdr_ack(b_sdr_ack), .sdr_dout(b_sdr_dout),
    .busy(b_busy), .grant(b_grant)
  );

  initial CLK_32M = 1'b0;
  always #5 CLK_32M = ~CLK_32M;

  // Downstream SDRAM models: ack toggles a_lat edges after the req toggle.
  always @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      a_sdr_ack <= 1'b0; a_sdr_dout <= '0; a_cnt <= 0;
    end else if (a_sdr_req != a_sdr_ack) begin
      if (a_cnt + 1 >= a_lat) begin
        a_sdr_ack  <= a_sdr_req;
        a_sdr_dout <= a_mode ? ~a_sdr_addr[15:0] : a_rdata;
        a_cnt      <= 0;
      end else a_cnt <= a_cnt + 1;
    end
  end

  always @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      b_sdr_ack <= 1'b0; b_sdr_dout <= '0; b_cnt <= 0;
    end else if (b_sdr_req != b_sdr_ack) begin
      if (b_cnt + 1 >= b_lat) begin
        b_sdr_ack  <= b_sdr_req;
        b_sdr_dout <= ~b_sdr_addr[15:0];
        b_cnt      <= 0;
      end else b_cnt <= b_cnt + 1;
    end
  end

  task automatic test_reset();
    tests++; if (a_m0_ack !== 1'b0) begin failed++; $display("FAIL rst_m0_ack got %b exp 0", a_m0_ack); end
    tests++; if (a_m1_ack !== 1'b0) begin failed++; $display("FAIL rst_m1_ack got %b exp 0", a_m1_ack); end
    tests++; if (a_sdr_req !== 1'b0) begin failed++; $display("FAIL rst_sdr_req got %b exp 0", a_sdr_req); end
    tests++; if (a_sdr_addr !== 24'h0) begin failed++; $display("FAIL rst_sdr_addr got %h exp 0", a_sdr_addr); end
    tests++; if (a_sdr_din !== 16'h0) begin failed++; $display("FAIL rst_sdr_din got %h exp 0", a_sdr_din); end
    tests++; if (a_sdr_wr_sel !== 2'b00) begin failed++; $display("FAIL rst_sdr_wr_sel got %b exp 00", a_sdr_wr_sel); end
    tests++; if (a_m0_dout !== 16'h0 || a_m1_dout !== 16'h0) begin failed++; $display("FAIL rst_dout got %h/%h exp 0/0", a_m0_dout, a_m1_dout); end
    tests++; if (a_busy !== 1'b0 || a_grant !== 1'b0) begin failed++; $display("FAIL rst_busy_grant got %b/%b exp 0/0", a_busy, a_grant); end
    tests++; if (b_busy !== 1'b0 || b_sdr_req !== 1'b0) begin failed++; $display("FAIL rst_b got busy %b req %b exp 0/0", b_busy, b_sdr_req); end
    @(negedge CLK_32M); reset_n = 1'b1;
    repeat (2) @(negedge CLK_32M);
    tests++; if (a_busy !== 1'b0 || a_sdr_req !== 1'b0) begin failed++; $display("FAIL idle_after_rst got busy %b req %b exp 0/0", a_busy, a_sdr_req); end
  endtask

  task automatic test_single_read();
    int busy_cycles;
    busy_cycles = 0;
    @(negedge CLK_32M);
    a_m0_addr = 24'h012345; a_m0_din = 16'h0; a_m0_wr_sel = 2'b00;
    a_lat = 5; a_mode = 1'b0; a_rdata = 16'hBEEF;
    a_m0_req = ~a_m0_req;
    @(posedge CLK_32M); #1;
    tests++; if (a_sdr_req !== 1'b1) begin failed++; $display("FAIL rd_sdr_req_on_grant got %b exp 1", a_sdr_req); end
    tests++; if (a_sdr_addr !== 24'h012345) begin failed++; $display("FAIL rd_sdr_addr got %h exp 012345", a_sdr_addr); end
    tests++; if (a_sdr_wr_sel !== 2'b00) begin failed++; $display("FAIL rd_sdr_wr_sel got %b exp 00", a_sdr_wr_sel); end
    tests++; if (a_busy !== 1'b1 || a_grant !== 1'b0) begin failed++; $display("FAIL rd_busy_grant got %b/%b exp 1/0", a_busy, a_grant); end
    for (int c = 0; c < 50 && a_m0_ack != a_m0_req; c++) begin
      @(negedge CLK_32M);
      if (a_busy) busy_cycles++;
    end
    tests++; if (a_m0_ack !== 1'b1) begin failed++; $display("FAIL rd_m0_ack got %b exp 1", a_m0_ack); end
    tests++; if (a_m0_dout !== 16'hBEEF) begin failed++; $display("FAIL rd_m0_dout got %h exp beef", a_m0_dout); end
    tests++; if (a_m1_ack !== 1'b0 || a_m1_dout !== 16'h0) begin failed++; $display("FAIL rd_m1_untouched got %b/%h exp 0/0000", a_m1_ack, a_m1_dout); end
    tests++; if (busy_cycles != 6) begin failed++; $display("FAIL rd_busy_cycles got %0d exp 6", busy_cycles); end
  endtask

  task automatic test_write_forwarding();
    @(negedge CLK_32M);
    a_m1_addr = 24'h800010; a_m1_din = 16'hA55A; a_m1_wr_sel = 2'b10;
    a_lat = 2; a_mode = 1'b0; a_rdata = 16'h1234;
    a_m1_req = ~a_m1_req;
    for (int c = 0; c < 50 && a_m1_ack != a_m1_req; c++) @(negedge CLK_32M);
    tests++; if (a_m1_ack !== 1'b1) begin failed++; $display("FAIL wr_m1_ack got %b exp 1", a_m1_ack); end
    tests++; if (a_sdr_din !== 16'hA55A) begin failed++; $display("FAIL wr_sdr_din got %h exp a55a", a_sdr_din); end
    tests++; if (a_sdr_wr_sel !== 2'b10) begin failed++; $display("FAIL wr_sdr_wr_sel got %b exp 10", a_sdr_wr_sel); end
    tests++; if (a_sdr_addr !== 24'h800010) begin failed++; $display("FAIL wr_sdr_addr got %h exp 800010", a_sdr_addr); end
    tests++; if (a_m1_dout !== 16'h0) begin failed++; $display("FAIL wr_m1_dout_hold got %h exp 0000", a_m1_dout); end
    tests++; if (a_grant !== 1'b1) begin failed++; $display("FAIL wr_grant got %b exp 1", a_grant); end
    tests++; if (a_m0_dout !== 16'hBEEF || a_m0_ack !== 1'b1) begin failed++; $display("FAIL wr_m0_untouched got %h/%b exp beef/1", a_m0_dout, a_m0_ack); end
    @(negedge CLK_32M);
    tests++; if (a_sdr_wr_sel !== 2'b10 || a_busy !== 1'b0) begin failed++; $display("FAIL wr_idle_hold got wr_sel %b busy %b exp 10/0", a_sdr_wr_sel, a_busy); end
  endtask

  task automatic test_round_robin();
    int   got[8];
    int   n;
    logic prev_busy;
    int   exp_order[4];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    n = 0;
    a_mode = 1'b1; a_lat = 2;
    for (int r = 0; r < 2; r++) begin
      @(negedge CLK_32M);
      a_m0_addr = 24'h000100 + 24'(r); a_m0_wr_sel = 2'b00;
      a_m1_addr = 24'h000200 + 24'(r); a_m1_wr_sel = 2'b00;
      a_m0_req = ~a_m0_req; a_m1_req = ~a_m1_req;
      prev_busy = a_busy;
      for (int c = 0; c < 100 && !(a_m0_ack == a_m0_req && a_m1_ack == a_m1_req && !a_busy); c++) begin
        @(negedge CLK_32M);
        if (a_busy && !prev_busy) begin
          if (n < 8) got[n] = int'(a_grant);
          n++;
        end
        prev_busy = a_busy;
      end
      tests++; if (a_m0_ack !== a_m0_req || a_m1_ack !== a_m1_req) begin failed++; $display("FAIL rr_round%0d_acks got %b%b exp %b%b", r, a_m0_ack, a_m1_ack, a_m0_req, a_m1_req); end
      tests++; if (a_m0_dout !== ~a_m0_addr[15:0]) begin failed++; $display("FAIL rr_round%0d_m0_dout got %h exp %h", r, a_m0_dout, ~a_m0_addr[15:0]); end
      tests++; if (a_m1_dout !== ~a_m1_addr[15:0]) begin failed++; $display("FAIL rr_round%0d_m1_dout got %h exp %h", r, a_m1_dout, ~a_m1_addr[15:0]); end
    end
    tests++; if (n != 4) begin failed++; $display("FAIL rr_grant_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (i < n && got[i] != exp_order[i]) begin failed++; $display("FAIL rr_order[%0d] got %0d exp %0d", i, got[i], exp_order[i]); end
    end
  endtask

  task automatic test_fixed_priority();
    int   got[8];
    int   n, n0;
    logic prev_busy;
    n = 0;
    b_lat = 2;
    @(negedge CLK_32M);
    b_m0_addr = 24'h000010; b_m0_wr_sel = 2'b00;
    b_m1_addr = 24'h000020; b_m1_wr_sel = 2'b00;
    b_m0_req = ~b_m0_req; b_m1_req = ~b_m1_req;
    n0 = 1;
    prev_busy = b_busy;
    for (int c = 0; c < 200 && !(n0 == 4 && b_m0_ack == b_m0_req && b_m1_ack == b_m1_req && !b_busy); c++) begin
      @(negedge CLK_32M);
      if (b_busy && !prev_busy) begin
        if (n < 8) got[n] = int'(b_grant);
        n++;
      end
      prev_busy = b_busy;
      if (b_m0_ack == b_m0_req && n0 < 4) begin
        b_m0_addr = b_m0_addr + 24'h1;
        b_m0_req  = ~b_m0_req;
        n0++;
      end
    end
    tests++; if (n != 5) begin failed++; $display("FAIL prio_grant_count got %0d exp 5", n); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (i < n && got[i] != ((i == 4) ? 1 : 0)) begin failed++; $display("FAIL prio_order[%0d] got %0d exp %0d", i, got[i], (i == 4) ? 1 : 0); end
    end
    tests++; if (b_m1_ack !== b_m1_req || b_m1_dout !== 16'hFFDF) begin failed++; $display("FAIL prio_m1_served got ack %b dout %h exp %b/ffdf", b_m1_ack, b_m1_dout, b_m1_req); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK_32M);
    a_m0_addr = 24'h000777; a_m0_wr_sel = 2'b00;
    a_lat = 20; a_mode = 1'b0; a_rdata = 16'hDEAD;
    a_m0_req = ~a_m0_req;
    repeat (3) @(negedge CLK_32M);
    tests++; if (a_busy !== 1'b1) begin failed++; $display("FAIL rm_pre_busy got %b exp 1", a_busy); end
    reset_n = 1'b0;
    a_m0_req = 1'b0; a_m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
    #1;
    tests++; if (a_busy !== 1'b0 || a_sdr_req !== 1'b0 || a_grant !== 1'b0) begin failed++; $display("FAIL rm_async_ctrl got busy %b req %b grant %b exp 000", a_busy, a_sdr_req, a_grant); end
    tests++; if (a_m0_ack !== 1'b0 || a_m1_ack !== 1'b0) begin failed++; $display("FAIL rm_async_acks got %b%b exp 00", a_m0_ack, a_m1_ack); end
    tests++; if (a_sdr_addr !== 24'h0 || a_sdr_wr_sel !== 2'b00 || a_sdr_din !== 16'h0) begin failed++; $display("FAIL rm_async_sdr got %h/%b/%h exp 0", a_sdr_addr, a_sdr_wr_sel, a_sdr_din); end
    tests++; if (a_m0_dout !== 16'h0 || a_m1_dout !== 16'h0) begin failed++; $display("FAIL rm_async_dout got %h/%h exp 0/0", a_m0_dout, a_m1_dout); end
    @(negedge CLK_32M); reset_n = 1'b1;
    @(negedge CLK_32M);
    a_m0_addr = 24'h000ABC; a_lat = 3; a_rdata = 16'hC0DE;
    a_m0_req = ~a_m0_req;
    for (int c = 0; c < 50 && a_m0_ack != a_m0_req; c++) @(negedge CLK_32M);
    tests++; if (a_m0_ack !== 1'b1) begin failed++; $display("FAIL rm_post_ack got %b exp 1", a_m0_ack); end
    tests++; if (a_m0_dout !== 16'hC0DE) begin failed++; $display("FAIL rm_post_dout got %h exp c0de", a_m0_dout); end
    tests++; if (a_sdr_addr !== 24'h000ABC || a_sdr_req !== 1'b1) begin failed++; $display("FAIL rm_post_sdr got %h/%b exp 000abc/1", a_sdr_addr, a_sdr_req); end
  endtask

  task automatic test_back_to_back();
    int   n, ntog, idx, last_done;
    logic prev_req, prev_ack;
    n = 0; ntog = 0; idx = 0; last_done = -1;
    a_lat = 1; a_mode = 1'b1; a_m0_wr_sel = 2'b00;
    @(negedge CLK_32M);
    prev_req = a_sdr_req; prev_ack = a_m0_ack;
    for (int c = 0; c < 100 && !(n == 3 && a_m0_ack == a_m0_req && !a_busy); c++) begin
      if (a_m0_ack == a_m0_req && n < 3) begin
        a_m0_addr = 24'h100000 + 24'(n * 16 + 3);
        a_m0_req  = ~a_m0_req;
        n++;
      end
      @(negedge CLK_32M);
      idx++;
      if (a_m0_ack != prev_ack) begin
        prev_ack  = a_m0_ack;
        last_done = idx;
        tests++; if (a_m0_dout !== ~a_m0_addr[15:0]) begin failed++; $display("FAIL b2b_dout got %h exp %h", a_m0_dout, ~a_m0_addr[15:0]); end
      end
      if (a_sdr_req != prev_req) begin
        prev_req = a_sdr_req;
        ntog++;
        tests++; if (idx <= last_done) begin failed++; $display("FAIL b2b_gap toggle at %0d completion at %0d exp later", idx, last_done); end
      end
      if (!a_busy) begin
        tests++; if (a_sdr_req !== a_sdr_ack) begin failed++; $display("FAIL b2b_parity got req %b ack %b exp equal", a_sdr_req, a_sdr_ack); end
      end
    end
    tests++; if (ntog != 3) begin failed++; $display("FAIL b2b_toggle_count got %0d exp 3", ntog); end
    tests++; if (a_m0_ack !== a_m0_req) begin failed++; $display("FAIL b2b_final_ack got %b exp %b", a_m0_ack, a_m0_req); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; failed = 0;
    reset_n = 1'b0;
    a_m0_addr = '0; a_m0_din = '0; a_m0_wr_sel = '0; a_m0_req = 1'b0;
    a_m1_addr = '0; a_m1_din = '0; a_m1_wr_sel = '0; a_m1_req = 1'b0;
    b_m0_addr = '0; b_m0_din = '0; b_m0_wr_sel = '0; b_m0_req = 1'b0;
    b_m1_addr = '0; b_m1_din = '0; b_m1_wr_sel = '0; b_m1_req = 1'b0;
    a_lat = 1; b_lat = 1; a_mode = 1'b0; a_rdata = '0;
    repeat (3) @(negedge CLK_32M);
    test_reset();
    test_single_read();
    test_write_forwarding();
    test_round_robin();
    test_fixed_priority();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
